// File: rtl/div_sequencer.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: 32-step restoring division beside the execute ALU.
// Stalls the pipeline while busy and returns one registered result with a one-cycle valid strobe.
module div_sequencer #(
    parameter int XLEN       = 32,
    parameter int STEP_CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_start,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_data_1,
    input  logic [XLEN-1:0] i_data_2,
    input  logic            i_kill,
    output logic            o_busy,
    output logic            o_stall,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [XLEN-1:0]       ZERO      = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]       ALL_ONES  = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]       MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [STEP_CNT_W-1:0] CNT_ZERO  = {STEP_CNT_W{1'b0}};
    localparam logic [STEP_CNT_W-1:0] CNT_ONE   = {{(STEP_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [STEP_CNT_W-1:0] LAST_STEP = STEP_CNT_W'(XLEN-1);

    state_t                state_q;
    logic [STEP_CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]       rem_q;
    logic [XLEN-1:0]       quo_q;
    logic [XLEN-1:0]       div_q;
    logic                  rem_sel_q;
    logic                  neg_quo_q;
    logic                  neg_rem_q;
    logic                  special_q;
    logic                  valid_q;
    logic [XLEN-1:0]       result_q;

    logic                  is_signed_s;
    logic                  a_neg_s;
    logic                  b_neg_s;
    logic [XLEN-1:0]       a_mag_s;
    logic [XLEN-1:0]       b_mag_s;
    logic                  div_zero_s;
    logic                  overflow_s;
    logic                  accept_s;
    logic [XLEN:0]         shifted_s;
    logic [XLEN:0]         diff_s;
    logic [XLEN-1:0]       rem_d;
    logic [XLEN-1:0]       quo_d;
    logic [XLEN-1:0]       result_d;

    assign is_signed_s = ~i_funct3[0];
    assign a_neg_s     = is_signed_s & i_data_1[XLEN-1];
    assign b_neg_s     = is_signed_s & i_data_2[XLEN-1];
    assign a_mag_s     = a_neg_s ? (ZERO - i_data_1) : i_data_1;
    assign b_mag_s     = b_neg_s ? (ZERO - i_data_2) : i_data_2;
    assign div_zero_s  = (i_data_2 == ZERO);
    assign overflow_s  = is_signed_s & (i_data_1 == MIN_NEG) & (i_data_2 == ALL_ONES);
    assign accept_s    = (state_q == IDLE) & i_start & i_funct3[2] & ~i_kill;

    assign o_busy   = (state_q == CALC) | (state_q == FIN);
    assign o_stall  = accept_s | o_busy;
    assign o_valid  = valid_q;
    assign o_result = result_q;

    // One restoring step on {rem,quo} plus the final sign fixup / result select.
    always_comb begin
        shifted_s = {rem_q, quo_q[XLEN-1]};
        diff_s    = shifted_s - {1'b0, div_q};
        rem_d     = shifted_s[XLEN-1:0];
        quo_d     = {quo_q[XLEN-2:0], 1'b0};
        if (!diff_s[XLEN]) begin
            rem_d = diff_s[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_d = shifted_s[XLEN-1:0];
        end
        if (rem_sel_q) begin
            result_d = neg_rem_q ? (ZERO - rem_q) : rem_q;
        end else begin
            result_d = neg_quo_q ? (ZERO - quo_q) : quo_q;
        end
    end

    // Sequencer FSM with all datapath registers and the registered result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= CNT_ZERO;
            rem_q     <= ZERO;
            quo_q     <= ZERO;
            div_q     <= ZERO;
            rem_sel_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            special_q <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= ZERO;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        rem_sel_q <= i_funct3[1];
                        cnt_q     <= CNT_ZERO;
                        div_q     <= b_mag_s;
                        state_q   <= CALC;
                        // Special cases preload the final answer and skip iteration via one CALC pass.
                        if (div_zero_s) begin
                            special_q <= 1'b1;
                            quo_q     <= ALL_ONES;
                            rem_q     <= i_data_1;
                            neg_quo_q <= 1'b0;
                            neg_rem_q <= 1'b0;
                        end else if (overflow_s) begin
                            special_q <= 1'b1;
                            quo_q     <= MIN_NEG;
                            rem_q     <= ZERO;
                            neg_quo_q <= 1'b0;
                            neg_rem_q <= 1'b0;
                        end else begin
                            special_q <= 1'b0;
                            quo_q     <= a_mag_s;
                            rem_q     <= ZERO;
                            neg_quo_q <= a_neg_s ^ b_neg_s;
                            neg_rem_q <= a_neg_s;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    if (i_kill) begin
                        state_q <= IDLE;
                    end else if (special_q) begin
                        state_q <= FIN;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + CNT_ONE;
                        if (cnt_q == LAST_STEP) begin
                            state_q <= FIN;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    if (!i_kill) begin
                        result_q <= result_d;
                        valid_q  <= 1'b1;
                    end else begin
                        result_q <= result_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
